// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract through one full-add cell, LSB first
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] op_a, op_b, sr;
  logic [CW-1:0] cnt;
  logic carry, hs, hc, hc2, sum, cout, last, accept;
  assign hs     = op_a[0] ^ op_b[0];
  assign hc     = op_a[0] & op_b[0];
  assign sum    = hs ^ carry;
  assign hc2    = hs & carry;
  assign cout   = hc | hc2;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign accept = (state != RUN) && start;
  // next state: RUN runs WIDTH bits, IDLE/DONE accept a start
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // state register with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == RUN;
      done  <= state_nx == DONE;
    end
  end
  // operand capture, serial datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sr    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sr    <= {sum, sr[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        S   <= {sum, sr[WIDTH-1:1]};
        C   <= cout;
        ovf <= carry ^ cout;
      end
    end
  end
endmodule
